// File: rtl/mem_bridge_initiator.sv
// mem_bridge_initiator: bus-master end of the main-memory bus.
// Accepts single-byte read/write requests (valid/ready) and runs a fixed
// IDLE -> SETUP -> ACCESS -> RECOVER sequence on the memory strobes.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   Req_Valid/Ready/Write/Addr/WData request handshake and payload
//   Rsp_Valid, Rsp_RData             completion pulse and read data
//   Busy                             bridge not idle
//   Addr, MEMDATA                    memory address, shared bidirectional data bus
//   MemBridge_Load                   active-low write strobe (memory writes on falling edge)
//   MemBridge_Direction              1 = read cycle in progress
//   Memory_Ack                       read enable to memory
module mem_bridge_initiator #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [15:0] Req_Addr,
  input  logic [7:0]  Req_WData,
  output logic        Rsp_Valid,
  output logic [7:0]  Rsp_RData,
  output logic        Busy,
  output logic [15:0] Addr,
  inout  wire  [7:0]  MEMDATA,
  output logic        MemBridge_Load,
  output logic        MemBridge_Direction,
  output logic        Memory_Ack
);

  localparam logic [3:0] SetupLd   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] AccessLd  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] RecoverLd = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic        load_q, load_d;
  logic        dir_q, dir_d;
  logic        ack_q, ack_d;
  logic        drive_q, drive_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;

  // All bus-side signals are computed one state ahead so that every strobe
  // and the bus drive enable come straight from a flop (glitch-free Load).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    load_d      = load_q;
    dir_d       = dir_q;
    ack_d       = ack_q;
    drive_d     = drive_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (Req_Valid) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          addr_d  = Req_Addr;
          wdata_d = Req_WData;
          write_d = Req_Write;
          dir_d   = !Req_Write;
          drive_d = Req_Write;  // write data is on the bus from SETUP entry
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
          cnt_d   = AccessLd;
          load_d  = !write_q;
          ack_d   = !write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d     = StRecover;
          cnt_d       = RecoverLd;
          load_d      = 1'b1;
          ack_d       = 1'b0;
          rsp_valid_d = 1'b1;
          // Memory is still enabled on this edge, so its data is valid here.
          if (!write_q) rdata_d = MEMDATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecover: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          drive_d = 1'b0;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      addr_q      <= 16'h0000;
      load_q      <= 1'b1;
      dir_q       <= 1'b0;
      ack_q       <= 1'b0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      dir_q       <= dir_d;
      ack_q       <= ack_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign Req_Ready           = (state_q == StIdle);
  assign Busy                = (state_q != StIdle);
  assign Rsp_Valid           = rsp_valid_q;
  assign Rsp_RData           = rdata_q;
  assign Addr                = addr_q;
  assign MemBridge_Load      = load_q;
  assign MemBridge_Direction = dir_q;
  assign Memory_Ack          = ack_q;
  assign MEMDATA             = drive_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_mem_bridge_initiator.sv
// Self-checking bench for mem_bridge_initiator: random and directed requests,
// a per-transaction timeline model for the bus strobes, and a response scoreboard
// backed by a byte-array memory reference.
module tb_mem_bridge_initiator;

  localparam int S = 1;
  localparam int A = 2;
  localparam int R = 1;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic [15:0] addr;
  wire  [7:0]  memdata;
  logic        load, dir, ack;

  mem_bridge_initiator dut (
    .clk                (clk),
    .rst                (rst),
    .Req_Valid          (req_valid),
    .Req_Ready          (req_ready),
    .Req_Write          (req_write),
    .Req_Addr           (req_addr),
    .Req_WData          (req_wdata),
    .Rsp_Valid          (rsp_valid),
    .Rsp_RData          (rsp_rdata),
    .Busy               (busy),
    .Addr               (addr),
    .MEMDATA            (memdata),
    .MemBridge_Load     (load),
    .MemBridge_Direction(dir),
    .Memory_Ack         (ack)
  );

  // Second instance with stretched timing.
  logic        r5_valid, r5_ready, r5_write;
  logic [15:0] r5_addr;
  logic [7:0]  r5_wdata;
  logic        rsp5_valid;
  logic [7:0]  rsp5_rdata;
  logic        busy5;
  logic [15:0] addr5;
  wire  [7:0]  md5;
  logic        load5, dir5, ack5;

  mem_bridge_initiator #(
    .SETUP_CYCLES  (2),
    .ACCESS_CYCLES (4),
    .RECOVER_CYCLES(1)
  ) dut5 (
    .clk                (clk),
    .rst                (rst),
    .Req_Valid          (r5_valid),
    .Req_Ready          (r5_ready),
    .Req_Write          (r5_write),
    .Req_Addr           (r5_addr),
    .Req_WData          (r5_wdata),
    .Rsp_Valid          (rsp5_valid),
    .Rsp_RData          (rsp5_rdata),
    .Busy               (busy5),
    .Addr               (addr5),
    .MEMDATA            (md5),
    .MemBridge_Load     (load5),
    .MemBridge_Direction(dir5),
    .Memory_Ack         (ack5)
  );

  // Memory models on the bus side.
  logic [7:0] mem  [0:65535];
  logic [7:0] mem5 [0:255];
  assign memdata = (dir && ack) ? mem[addr] : 8'bz;
  assign md5     = (dir5 && ack5) ? mem5[addr5[7:0]] : 8'bz;
  always @(negedge load) mem[addr] <= memdata;
  always @(negedge load5) mem5[addr5[7:0]] <= md5;

  // Reference view of memory contents.
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic        chk_en = 1'b0;
  logic        inflight = 1'b0;
  logic        fl_wr = 1'b0;
  logic [7:0]  fl_wd = 8'h00;
  logic [15:0] fl_addr = 16'h0000;
  int          fl_acc = -100;
  logic [7:0]  last_rd = 8'h00;
  logic        b2b = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Timeline monitor and response scoreboard.
  int   rel;
  logic act_w, strobe_w;
  exp_t e;
  always @(negedge clk) begin
    if (chk_en) begin
      rel      = cyc - fl_acc;
      act_w    = inflight && rel >= 1 && rel <= S + A + R;
      strobe_w = act_w && rel >= S + 1 && rel <= S + A;
      check("bus_timeline", 32'({load, ack, dir, req_ready, busy, rsp_valid}),
            32'({!(strobe_w && fl_wr), strobe_w && !fl_wr, act_w && !fl_wr,
                 !act_w, act_w, act_w && rel == S + A + 1}));
      if (!(load == 1'b0 && ack == 1'b1)) begin end else check("load_ack_overlap", 32'd1, 32'd0);
      if (act_w) check("addr_held", 32'(addr), 32'(fl_addr));
      if (act_w && fl_wr) check("write_data_on_bus", 32'(memdata), 32'(fl_wd));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          if (!e.wr) begin
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
            last_rd = e.data;
          end else begin
            check("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_rd));
          end
        end
      end
    end
  end

  // Issue one request; returns just after the accepting edge. 'hold' keeps
  // Req_Valid high (with scrambled payload) so the next request is back-to-back.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input logic hold);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept_gap", 32'(cyc - fl_acc), 32'(S + A + R + 1));
    fl_acc   = cyc;
    fl_wr    = wr;
    fl_wd    = d;
    fl_addr  = a;
    inflight = 1'b1;
    if (wr) begin
      ref_mem[a] = d;
      sb.push_back('{wr: 1'b1, data: 8'h00, due: cyc + S + A + 1});
    end else begin
      sb.push_back('{wr: 1'b0, data: ref_mem[a], due: cyc + S + A + 1});
    end
    b2b = hold;
    @(posedge clk);
    #1;
    req_valid = hold;
    req_write = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic do_reset(input int n);
    chk_en    = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    r5_valid  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("reset_outputs", 32'({load, dir, ack, busy, rsp_valid, rsp_rdata}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    end
    sb.delete();
    inflight = 1'b0;
    last_rd  = 8'h00;
    b2b      = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({req_ready, rsp_valid}), 32'({1'b1, 1'b0}));
    chk_en = 1'b1;
  endtask

  task automatic run5(input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    r5_valid = 1'b1;
    r5_write = wr;
    r5_addr  = a;
    r5_wdata = d;
    check("p5_ready", 32'(r5_ready), 32'd1);
    @(posedge clk);
    #1;
    r5_valid = 1'b0;
    r5_addr  = 16'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("p5_load", 32'(load5), 32'(!(wr && k >= 3 && k <= 6)));
      check("p5_ack", 32'(ack5), 32'(!wr && k >= 3 && k <= 6));
      check("p5_rsp_valid", 32'(rsp5_valid), 32'(k == 7));
      if (!wr && k == 7) check("p5_rdata", 32'(rsp5_rdata), 32'(d));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    end
    for (int i = 0; i < 256; i++) mem5[i] = 8'h00;
    mem[16'h1234]     = 8'hA5;
    ref_mem[16'h1234] = 8'hA5;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    r5_valid  = 1'b0;
    r5_write  = 1'b0;
    r5_addr   = 16'h0000;
    r5_wdata  = 8'h00;
    rst       = 1'b1;
    do_reset(3);

    // Reset held 3 cycles in the middle of a read.
    issue(1'b0, 16'h0200, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    do_reset(3);

    // Directed read, write then read-back.
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    issue(1'b1, 16'h8001, 8'h5A, 1'b0);
    issue(1'b0, 16'h8001, 8'h00, 1'b0);

    // Back-to-back read then write with Req_Valid held high.
    issue(1'b0, 16'h8001, 8'h00, 1'b1);
    issue(1'b1, 16'h8002, 8'hC7, 1'b1);
    issue(1'b0, 16'h8002, 8'h00, 1'b0);

    // Random traffic, including ROM-range writes.
    for (int t = 0; t < 150; t++) begin
      base = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0100;
      issue(1'($urandom), base + 16'($urandom_range(0, 15)), 8'($urandom),
            ($urandom_range(0, 2) == 0));
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (S + A + R + 2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Reset in the first ACCESS cycle of a write, then a normal transaction.
    issue(1'b1, 16'h9999, 8'hC3, 1'b0);
    repeat (S + 1) @(negedge clk);
    do_reset(1);
    issue(1'b1, 16'h8005, 8'h3E, 1'b0);
    issue(1'b0, 16'h8005, 8'h00, 1'b0);
    repeat (S + A + R + 2) @(negedge clk);
    check("scoreboard_drained_end", 32'(sb.size()), 32'd0);

    // Stretched timing instance: write then read back.
    run5(1'b1, 16'h8010, 8'h77);
    run5(1'b0, 16'h8010, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
